// File: rtl/i2s_tx_engine.sv
// i2s_tx_engine
// I2S / left-justified TDM serialiser clocked entirely by the audio master
// clock. Channel-tagged samples arrive on an AXI-Stream slave and are queued
// in an internal FIFO. Frames of CHANNELS x 32-bit slots are generated from
// aud_mclk using a divider that is latched at every frame start.
//
// Ports
//   aud_mclk, aud_mrst     : clock and synchronous active-high reset
//   s_axis_aud_*           : sample stream (tdata MSB-aligned, tid = channel)
//   cfg_enable             : run request (a disable completes the current frame)
//   cfg_mode               : 0 = I2S (one-bit delay), 1 = left-justified
//   cfg_sclk_div           : sclk half-period minus one, in mclk cycles
//   sclk_out, lrclk_out,
//   sdata_out              : serial audio outputs
//   fifo_level             : number of stored samples
//   underrun, misalign     : one-cycle event pulses
//   active                 : high while frames are being generated
module i2s_tx_engine #(
  parameter int DATA_W     = 24,
  parameter int CHANNELS   = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             aud_mclk,
  input  logic             aud_mrst,
  input  logic [31:0]      s_axis_aud_tdata,
  input  logic [2:0]       s_axis_aud_tid,
  input  logic             s_axis_aud_tvalid,
  output logic             s_axis_aud_tready,
  input  logic             cfg_enable,
  input  logic             cfg_mode,
  input  logic [7:0]       cfg_sclk_div,
  output logic             sclk_out,
  output logic             lrclk_out,
  output logic             sdata_out,
  output logic [LVL_W-1:0] fifo_level,
  output logic             underrun,
  output logic             misalign,
  output logic             active
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] CH_LVL    = LVL_W'(CHANNELS);
  localparam logic [2:0]       LAST_SLOT = 3'(CHANNELS - 1);
  localparam logic [2:0]       HALF_SLOT = 3'(CHANNELS / 2);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  // Sample storage
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0]  level_reg;
  logic [2:0]        wr_ch_reg;

  // Frame engine
  state_t      state_reg;
  logic [8:0]  phase_reg;
  logic [7:0]  div_reg;
  logic        mode_reg;
  logic        filled_reg;
  logic [4:0]  bit_reg;
  logic [2:0]  slot_reg;
  logic [31:0] shift_reg;
  logic        delay_reg;
  logic        sclk_reg, lrclk_reg, sdata_reg;
  logic        underrun_reg, misalign_reg;

  logic              hs, push, bad, pop;
  logic [DATA_W-1:0] head_data;
  logic [31:0]       head_word;
  logic              boundary, frame_end, start_idle, frame_start, go_idle;
  logic              emit, slot_start, start_fill, filled_next, mode_next;
  logic              new_l, sdata_next;
  logic [4:0]        bit_next;
  logic [2:0]        slot_next;
  logic [31:0]       shift_next;

  assign s_axis_aud_tready = (level_reg < DEPTH_LVL);
  assign hs   = s_axis_aud_tvalid & s_axis_aud_tready;
  assign push = hs & (s_axis_aud_tid == wr_ch_reg);
  assign bad  = hs & (s_axis_aud_tid != wr_ch_reg);

  assign head_data = mem[rd_ptr_reg];

  // Expand the stored sample into a 32-bit slot word: sample bits MSB first,
  // zero padding below.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_slot_word
      if (gi < DATA_W) begin : g_data
        assign head_word[31-gi] = head_data[DATA_W-1-gi];
      end else begin : g_pad
        assign head_word[31-gi] = 1'b0;
      end
    end
    if (DATA_W < 32) begin : g_low_bits
      logic unused_low_bits;
      assign unused_low_bits = ^s_axis_aud_tdata[31-DATA_W:0];
    end
  endgenerate

  always_comb begin
    // Falling sclk edge: the phase counter has spent 2(D+1) cycles in the bit.
    boundary    = (state_reg == ST_RUN) && (phase_reg == {div_reg, 1'b1});
    frame_end   = boundary && (bit_reg == 5'd31) && (slot_reg == LAST_SLOT);
    start_idle  = (state_reg == ST_IDLE) && cfg_enable;
    frame_start = start_idle || (frame_end && cfg_enable);
    go_idle     = frame_end && !cfg_enable;
    emit        = start_idle || boundary;
    start_fill  = (level_reg >= CH_LVL);
    filled_next = frame_start ? start_fill : filled_reg;
    mode_next   = frame_start ? cfg_mode : mode_reg;
    slot_start  = emit && (frame_start || (bit_reg == 5'd31)) && !go_idle;
    pop         = slot_start && filled_next;
    bit_next    = frame_start ? 5'd0 : bit_reg + 5'd1;
    slot_next   = frame_start ? 3'd0 :
                  ((bit_reg == 5'd31) ? slot_reg + 3'd1 : slot_reg);
    new_l       = slot_start ? (pop & head_word[31]) : shift_reg[31];
    shift_next  = slot_start ? (pop ? {head_word[30:0], 1'b0} : 32'd0)
                             : {shift_reg[30:0], 1'b0};
    // I2S carries the previous bit; delay_reg is cleared whenever idle so the
    // first bit after IDLE is zero.
    sdata_next  = mode_next ? new_l : delay_reg;
  end

  always_ff @(posedge aud_mclk) begin
    if (push) begin
      mem[wr_ptr_reg] <= s_axis_aud_tdata[31 -: DATA_W];
    end
  end

  always_ff @(posedge aud_mclk) begin
    if (aud_mrst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      wr_ch_reg  <= 3'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
        wr_ch_reg  <= (wr_ch_reg == LAST_SLOT) ? 3'd0 : wr_ch_reg + 3'd1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LVL_W'(1);
        2'b01:   level_reg <= level_reg - LVL_W'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  always_ff @(posedge aud_mclk) begin
    if (aud_mrst) begin
      state_reg    <= ST_IDLE;
      phase_reg    <= 9'd0;
      div_reg      <= 8'd0;
      mode_reg     <= 1'b0;
      filled_reg   <= 1'b0;
      bit_reg      <= 5'd0;
      slot_reg     <= 3'd0;
      shift_reg    <= 32'd0;
      delay_reg    <= 1'b0;
      sclk_reg     <= 1'b0;
      lrclk_reg    <= 1'b0;
      sdata_reg    <= 1'b0;
      underrun_reg <= 1'b0;
      misalign_reg <= 1'b0;
    end else begin
      misalign_reg <= bad;
      underrun_reg <= frame_start && !start_fill;
      if (frame_start) begin
        state_reg  <= ST_RUN;
        div_reg    <= cfg_sclk_div;
        mode_reg   <= cfg_mode;
        filled_reg <= start_fill;
      end
      if (go_idle) begin
        state_reg <= ST_IDLE;
        phase_reg <= 9'd0;
        bit_reg   <= 5'd0;
        slot_reg  <= 3'd0;
        shift_reg <= 32'd0;
        delay_reg <= 1'b0;
        sclk_reg  <= 1'b0;
        lrclk_reg <= 1'b0;
        sdata_reg <= 1'b0;
      end else if (emit) begin
        phase_reg <= 9'd0;
        sclk_reg  <= 1'b0;
        bit_reg   <= bit_next;
        slot_reg  <= slot_next;
        shift_reg <= shift_next;
        sdata_reg <= sdata_next;
        delay_reg <= new_l;
        lrclk_reg <= (slot_next >= HALF_SLOT);
      end else if (state_reg == ST_RUN) begin
        phase_reg <= phase_reg + 9'd1;
        if (phase_reg == {1'b0, div_reg}) begin
          sclk_reg <= 1'b1;
        end
      end
    end
  end

  assign sclk_out   = sclk_reg;
  assign lrclk_out  = lrclk_reg;
  assign sdata_out  = sdata_reg;
  assign fifo_level = level_reg;
  assign underrun   = underrun_reg;
  assign misalign   = misalign_reg;
  assign active     = (state_reg == ST_RUN);

endmodule

// File: tb/tb_i2s_tx_engine.sv
// Bench for i2s_tx_engine: a frame-arithmetic reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_i2s_tx_engine;
  localparam int DW    = 24;
  localparam int CH    = 2;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   tdata = 32'd0;
  logic [2:0]    tid = 3'd0;
  logic          tvalid = 1'b0;
  logic          en = 1'b0;
  logic          mode = 1'b0;
  logic [7:0]    div = 8'd0;
  logic          tready, sclk_out, lrclk_out, sdata_out, underrun, misalign, active;
  logic [LW-1:0] fifo_level;

  i2s_tx_engine #(.DATA_W(DW), .CHANNELS(CH), .FIFO_DEPTH(DEPTH), .LVL_W(LW)) dut (
    .aud_mclk(clk), .aud_mrst(rst),
    .s_axis_aud_tdata(tdata), .s_axis_aud_tid(tid), .s_axis_aud_tvalid(tvalid),
    .s_axis_aud_tready(tready),
    .cfg_enable(en), .cfg_mode(mode), .cfg_sclk_div(div),
    .sclk_out(sclk_out), .lrclk_out(lrclk_out), .sdata_out(sdata_out),
    .fifo_level(fifo_level), .underrun(underrun), .misalign(misalign), .active(active)
  );

  initial forever #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mq[$];
  int          m_wrch = 0;
  bit          m_run = 0, m_mode = 0, m_filled = 0, m_prev = 0;
  bit          m_ur = 0, m_mis = 0, m_valid = 0;
  int          m_t = 0, m_d = 0;
  logic [31:0] m_samp [8];

  // Left-justified bit n of the current frame.
  function automatic bit lbit(input int n);
    int s, b;
    s = n / 32;
    b = n % 32;
    if (!m_filled || b >= DW) return 1'b0;
    return m_samp[s][31-b];
  endfunction

  task automatic model_step();
    bit tr, start;
    tr    = (mq.size() < DEPTH);
    m_ur  = 0;
    m_mis = 0;
    start = 0;
    if (rst) begin
      mq.delete();
      m_wrch = 0; m_run = 0; m_t = 0; m_prev = 0; m_filled = 0;
      m_valid = 1;
      return;
    end
    if (!m_run) begin
      if (en) start = 1;
    end else begin
      m_t++;
      if (m_t == CH * 32 * 2 * (m_d + 1)) begin
        if (en) begin
          m_prev = lbit(CH * 32 - 1);
          start  = 1;
        end else begin
          m_run  = 0;
          m_prev = 0;
        end
      end
    end
    if (start) begin
      m_run    = 1;
      m_t      = 0;
      m_d      = int'(div);
      m_mode   = mode;
      m_filled = (mq.size() >= CH);
      m_ur     = !m_filled;
      if (m_filled) for (int s = 0; s < CH; s++) m_samp[s] = mq[s];
    end
    if (m_run && m_filled && (m_t % (32 * 2 * (m_d + 1)) == 0)) void'(mq.pop_front());
    if (tvalid && tr) begin
      if (int'(tid) == m_wrch) begin
        mq.push_back(tdata);
        m_wrch = (m_wrch + 1) % CH;
      end else begin
        m_mis = 1;
      end
    end
  endtask

  function automatic logic [7+LW-1:0] model_outputs();
    bit sc, lr, sd;
    int p, n;
    sc = 0; lr = 0; sd = 0;
    if (m_run) begin
      p  = 2 * (m_d + 1);
      n  = m_t / p;
      sc = (m_t % p) >= (m_d + 1);
      lr = (n / 32) >= (CH / 2);
      sd = m_mode ? lbit(n) : ((n == 0) ? m_prev : lbit(n - 1));
    end
    return {sc, lr, sd, m_ur, m_mis, m_run, (mq.size() < DEPTH), LW'(mq.size())};
  endfunction

  // ---------------- monitor: compare, capture, count ----------------
  logic        cap_en = 1'b0, cnt_clr = 1'b0;
  logic [63:0] cap = 64'd0;
  int          cap_n = 0, cyc_cnt = 0, last_rise = 0, period = 0;
  bit          rise_seen = 0, prev_sclk = 0;
  int          ur_cnt = 0, mis_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      cyc_cnt++;
      if (m_valid)
        check($sformatf("outputs@cycle%0d", cyc_cnt),
              64'({sclk_out, lrclk_out, sdata_out, underrun, misalign, active, tready, fifo_level}),
              64'(model_outputs()));
      if (!cap_en) begin
        cap = 64'd0; cap_n = 0; rise_seen = 0;
      end else if (sclk_out && !prev_sclk && cap_n < 64) begin
        cap = {cap[62:0], sdata_out};
        cap_n++;
        if (rise_seen) period = cyc_cnt - last_rise;
        last_rise = cyc_cnt;
        rise_seen = 1;
      end
      prev_sclk = sclk_out;
      if (cnt_clr) begin
        ur_cnt = 0; mis_cnt = 0;
      end else begin
        if (underrun === 1'b1) ur_cnt++;
        if (misalign === 1'b1) mis_cnt++;
      end
      model_step();
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [2:0] id);
    tvalid = 1'b1; tdata = d; tid = id;
    cyc();
    tvalid = 1'b0;
  endtask

  task automatic clear_counts();
    cnt_clr = 1'b1; cyc(); cnt_clr = 1'b0;
  endtask

  task automatic one_frame(input logic m);
    div = 8'd1; mode = m;
    push(32'hABCDEF00, 3'd0);
    push(32'h12345600, 3'd1);
    check("level_after_two_pushes", 64'(fifo_level), 64'd2);
    cap_en = 1'b0; cyc(); cap_en = 1'b1;
    en = 1'b1; cyc(); en = 1'b0;
    repeat (300) cyc();
    check("captured_bit_count", 64'(cap_n), 64'd64);
    check("sclk_period", 64'(period), 64'd4);
    check("level_after_frame", 64'(fifo_level), 64'd0);
    check("inactive_after_frame", 64'(active), 64'd0);
  endtask

  logic [63:0] lit;
  int          vrate;

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_outputs", 64'({sclk_out, lrclk_out, sdata_out, underrun, misalign, active}), 64'd0);
    check("reset_level", 64'(fifo_level), 64'd0);

    lit = 64'hABCDEF00_12345600;
    one_frame(1'b1);
    check("lj_stream", cap, lit);
    one_frame(1'b0);
    check("i2s_stream", cap, lit >> 1);

    // Empty FIFO: three underrun frames, then the disable completes.
    clear_counts();
    div = 8'd0; mode = 1'b1; en = 1'b1;
    repeat (300) cyc();
    en = 1'b0;
    repeat (200) cyc();
    check("underrun_pulses", 64'(ur_cnt), 64'd3);
    check("idle_after_underrun", 64'(active), 64'd0);

    // Misaligned channel tag.
    clear_counts();
    push(32'h11111100, 3'd0);
    push(32'h22222200, 3'd0);
    push(32'h33333300, 3'd1);
    cyc();
    check("misalign_level", 64'(fifo_level), 64'd2);
    check("misalign_pulses", 64'(mis_cnt), 64'd1);
    push(32'h44444400, 3'd0);
    check("wr_ch_resync", 64'(fifo_level), 64'd3);
    rst = 1'b1; cyc(); rst = 1'b0;

    // Fill to the top while disabled.
    for (int i = 0; i < 18; i++) push(32'(i) << 8, 3'(i % 2));
    check("full_level", 64'(fifo_level), 64'd16);
    check("full_tready", 64'(tready), 64'd0);

    // Disable mid-frame: frame completes, two samples consumed.
    div = 8'd2; mode = 1'b0; en = 1'b1;
    repeat (100) cyc();
    en = 1'b0;
    for (int i = 0; i < 1000 && active; i++) cyc();
    check("disable_completes_frame", 64'(active), 64'd0);
    check("level_after_disable", 64'(fifo_level), 64'd14);
    check("idle_outputs", 64'({sclk_out, lrclk_out, sdata_out}), 64'd0);

    // Reset mid-frame.
    en = 1'b1;
    repeat (50) cyc();
    rst = 1'b1; cyc(); rst = 1'b0; en = 1'b0;
    check("midframe_reset_outputs",
          64'({sclk_out, lrclk_out, sdata_out, underrun, misalign, active}), 64'd0);
    check("midframe_reset_level", 64'(fifo_level), 64'd0);

    // Random traffic against the model.
    en = 1'b1;
    vrate = 20;
    for (int c = 0; c < 6000; c++) begin
      if (c % 500 == 0) vrate = 4 + int'($urandom_range(0, 150));
      tvalid = ($urandom % vrate) == 0;
      tdata  = $urandom;
      tid    = (($urandom % 12) == 0) ? 3'($urandom % 8) : 3'(m_wrch);
      if (($urandom % 250) == 0) en = ~en;
      if (($urandom % 300) == 0) div = 8'($urandom % 4);
      if (($urandom % 300) == 0) mode = ~mode;
      rst = (($urandom % 2000) == 0);
      cyc();
    end
    tvalid = 1'b0; rst = 1'b0; en = 1'b0;
    repeat (4) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
